// File: rtl/offchip_mem_arbiter_pkg.sv
// Shared definitions for the offchip memory read arbiter: FSM states,
// requester port ids and default widths.
package offchip_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF      = 6;
  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/offchip_mem_arbiter_if.sv
// Request/response and memory-side signals of the offchip memory arbiter.
// slave: the arbiter's view; master: the requesters plus memory around it.
interface offchip_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              resp0_valid;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_data_ready;
  logic [DATA_W-1:0] mem_data_bus;

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
           mem_data_ready, mem_data_bus,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_data, resp_err, mem_read_enable, mem_address
  );

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
           mem_data_ready, mem_data_bus,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp_data, resp_err, mem_read_enable, mem_address
  );
endinterface

// File: rtl/offchip_mem_arbiter_arb_picker_2.sv
// Two-way request picker. Build option ARB_ROUND_ROBIN_EN selects
// round-robin between simultaneous requests; otherwise port 0 has fixed
// priority. The last-grant register is the round-robin pointer and also
// tells the top which port owns the transaction in flight.
module arb_picker_2
  import offchip_mem_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     valid0,
  input  logic     valid1,
  input  logic     accept,
  output port_id_t grant_id,
  output port_id_t last_grant
);

  // Choose the winner among the currently valid requests
  always_comb begin
    grant_id = PORT0;
    if (valid0 && valid1) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_grant == PORT0) grant_id = PORT1;
      else                     grant_id = PORT0;
`else
      grant_id = PORT0;
`endif
    end else if (valid1) begin
      grant_id = PORT1;
    end
  end

  // Remember the port granted last; reset value makes port 0 favoured
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      last_grant <= PORT1;
    else if (accept) last_grant <= grant_id;
  end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Shares the single-port offchip memory read channel between an
// instruction-cache miss port (0) and a data-cache miss port (1).
// One read in flight; a watchdog aborts reads that never complete.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin arbitration).
module offchip_mem_arbiter
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic clock,
  input logic reset,
  offchip_mem_arbiter_if.slave bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  // Abort fires in the WAIT cycle that completes TIMEOUT_CYC cycles
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_q;
  logic              rd_en_q;
  logic              resp0_q;
  logic              resp1_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              idle_ok;
  logic              accept;
  port_id_t          grant_id;
  port_id_t          last_grant;
  logic [ADDR_W-1:0] sel_addr;

  arb_picker_2 u_picker (
    .clock      (clock),
    .reset      (reset),
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .accept     (accept),
    .grant_id   (grant_id),
    .last_grant (last_grant)
  );

  // Accept only in IDLE, and never while reset is asserted
  always_comb begin
    idle_ok        = (state == ST_IDLE) && reset;
    accept         = idle_ok && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = idle_ok && bus.req0_valid && (grant_id == PORT0);
    bus.req1_ready = idle_ok && bus.req1_valid && (grant_id == PORT1);
    sel_addr       = (grant_id == PORT1) ? bus.req1_addr : bus.req0_addr;
  end

  // Transaction FSM with address latch, watchdog and response register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_en_q <= 1'b0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= sel_addr;
            wd_q    <= '0;
            rd_en_q <= 1'b1;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_data_ready || (wd_q == WD_LAST)) begin
            // data_ready takes precedence over a coincident timeout
            data_q  <= bus.mem_data_ready ? bus.mem_data_bus : '0;
            err_q   <= !bus.mem_data_ready;
            rd_en_q <= 1'b0;
            resp0_q <= (last_grant == PORT0);
            resp1_q <= (last_grant == PORT1);
            state   <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered outputs onto the interface
  always_comb begin
    bus.mem_read_enable = rd_en_q;
    bus.mem_address     = addr_q;
    bus.resp0_valid     = resp0_q;
    bus.resp1_valid     = resp1_q;
    bus.resp_data       = data_q;
    bus.resp_err        = err_q;
  end

endmodule
